// File: rtl/wishbone_arbiter_n.sv
// N-master Wishbone arbiter: fixed-priority or round-robin, registered one-hot grant, 1-cycle arbitration, idle turnaround between owners.
// Optional stuck-transfer timeout enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_arbiter_n #(
    parameter int NUM_MASTERS    = 3,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int RR_MODE        = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_cyc,
    input  logic [NUM_MASTERS-1:0]        m_stb,
    input  logic [NUM_MASTERS-1:0]        m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_adr,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_dat_w,
    output logic [DATA_W-1:0]             m_dat_r,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_err,
    output logic                          s_cyc,
    output logic                          s_stb,
    output logic                          s_we,
    output logic [ADDR_W-1:0]             s_adr,
    output logic [DATA_W-1:0]             s_dat_w,
    input  logic [DATA_W-1:0]             s_dat_r,
    input  logic                          s_ack,
    output logic [NUM_MASTERS-1:0]        grant
);

    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [PTR_W-1:0]       rr_ptr_q;

    logic [PTR_W-1:0]       base;
    logic [PTR_W-1:0]       win_hi;
    logic [PTR_W-1:0]       win_lo;
    logic [PTR_W-1:0]       win_idx;
    logic [PTR_W-1:0]       rr_ptr_d;
    logic                   found_hi;
    logic [NUM_MASTERS-1:0] win_oh;
    logic                   tmo_hit;
    logic                   rel_own;

    // Two-pass search: first requester at or above base, else lowest requester (wrap-around).
    always_comb begin
        base     = (RR_MODE != 0) ? rr_ptr_q : '0;
        win_hi   = '0;
        win_lo   = '0;
        found_hi = 1'b0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (m_cyc[i]) begin
                win_lo = PTR_W'(i);
                if (i >= int'(base)) begin
                    win_hi   = PTR_W'(i);
                    found_hi = 1'b1;
                end
            end
        end
        win_idx = found_hi ? win_hi : win_lo;
        win_oh  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            win_oh[i] = (win_idx == PTR_W'(i));
        end
        rr_ptr_d = (win_idx == PTR_W'(NUM_MASTERS - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                s_adr   = s_adr   | m_adr[i*ADDR_W +: ADDR_W];
                s_dat_w = s_dat_w | m_dat_w[i*DATA_W +: DATA_W];
            end
        end
    end

    assign s_cyc   = |(m_cyc & grant_q);
    assign s_stb   = |(m_stb & grant_q);
    assign s_we    = |(m_we  & grant_q);
    assign m_ack   = grant_q & {NUM_MASTERS{s_ack}};
    assign m_dat_r = s_dat_r;
    assign grant   = grant_q;
    assign rel_own = !s_cyc || tmo_hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|m_cyc) begin
                        grant_q  <= win_oh;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= BUSY;
                    end
                end
                BUSY: begin
                    if (rel_own) begin
                        grant_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Error is raised while the grant is still held, so m_err is never seen with grant=0.
    assign tmo_hit = (state_q == BUSY) && s_cyc && s_stb && !s_ack
                     && (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
    assign m_err   = grant_q & {NUM_MASTERS{tmo_hit}};

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q != BUSY || rel_own || s_ack) begin
            tmo_cnt_q <= '0;
        end else if (s_stb) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign m_err   = '0;
`endif

endmodule

// File: doc/wishbone_arbiter_n.md
Name: wishbone_arbiter_n

Overview:
- Parametrised N-master Wishbone arbiter; next generation of the fixed 3-master arbiter in front of the board memory.
- Sits between game-logic or VGA masters and one shared Wishbone slave (wishbone_board_mem); runs in the clk100MHz domain.
- Adds configurable master count, fixed-priority or round-robin mode, a registered one-hot grant, and an optional stuck-transfer timeout.

Parameters:
- NUM_MASTERS, 3: number of masters, 2..8.
- ADDR_W, 16: address width.
- DATA_W, 8: data width.
- RR_MODE, 0: 0 = fixed priority (master 0 highest); 1 = round robin.
- TIMEOUT_CYCLES, 255: stall limit in cycles (used only with WB_ARB_TIMEOUT_EN), 1..65535.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- m_cyc  in  NUM_MASTERS  per-master cycle request.
- m_stb  in  NUM_MASTERS  per-master strobe.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_adr  in  NUM_MASTERS*ADDR_W  packed addresses; master i in slice [i*ADDR_W +: ADDR_W].
- m_dat_w  in  NUM_MASTERS*DATA_W  packed write data, same packing.
- m_dat_r  out  DATA_W  slave read data, broadcast to all masters.
- m_ack  out  NUM_MASTERS  per-master acknowledge.
- m_err  out  NUM_MASTERS  per-master error (timeout).
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  ADDR_W  to slave.
- s_dat_w  out  DATA_W  to slave.
- s_dat_r  in  DATA_W  from slave.
- s_ack  in  1  from slave.
- grant  out  NUM_MASTERS  registered one-hot grant; all-zero when idle.

Behaviour:
- Reset: grant=0, rr_ptr=0, timeout counter=0, state=IDLE. s_cyc, s_stb, m_ack, m_err are all 0 while grant=0.
- States: IDLE, BUSY.
- IDLE:
  - If any m_cyc is high, pick a winner and load grant one-hot on the next edge; go to BUSY.
  - Arbitration latency: 1 cycle from m_cyc to grant.
- Winner selection:
  - RR_MODE=0: lowest index with m_cyc high.
  - RR_MODE=1: first index with m_cyc high, searching from rr_ptr upward with wrap-around modulo NUM_MASTERS.
  - On every grant, rr_ptr <= winner+1, wrapping to 0 at NUM_MASTERS.
- BUSY:
  - s_cyc, s_stb, s_we, s_adr and s_dat_w are combinationally muxed from the granted master.
  - m_ack[g] = s_ack. All other m_ack bits are 0.
  - m_dat_r = s_dat_r at all times.
  - Grant is held while m_cyc[g] stays high. Multiple stb/ack beats (block transfers) need no re-arbitration.
  - When m_cyc[g]=0 (sampled at the edge), grant <= 0 and state returns to IDLE.
  - There is one idle turnaround cycle between owners; back-to-back grants to different masters are never allowed.
- Requests from non-granted masters are held off (no ack) and are never dropped.
- s_ack arriving with state=IDLE is ignored.
- Simultaneous drop of m_cyc[g] and new requests: the transition to IDLE takes priority; arbitration runs in the following cycle.
- rst mid-transfer: grant clears on that edge. Slave outputs go low the same cycle via the mux. An in-flight ack is discarded.
- NUM_MASTERS=1 degenerates to a pass-through with a 1-cycle grant delay.

Optional Feature:
- Macro: WB_ARB_TIMEOUT_EN.
- With the macro defined:
  - A 16-bit counter increments each BUSY cycle in which s_stb=1 and s_ack=0.
  - The counter clears on s_ack or on any grant change.
  - When the counter reaches TIMEOUT_CYCLES: m_err[g] pulses 1 for one cycle, grant <= 0, and state returns to IDLE.
  - The timed-out master loses ownership even if m_cyc stays high. In RR_MODE=1, rr_ptr advances past it.
- Without the macro:
  - m_err is tied to 0.
  - No counter logic is synthesised.
  - A stalled slave holds the grant indefinitely.

Test Plan:
- Reset: rst=1 for 3 cycles with all m_cyc=1 -> grant=0, s_cyc=0, m_ack=0. First grant appears 1 cycle after rst falls.
- Fixed priority: NUM_MASTERS=3, RR_MODE=0, m_cyc=3'b110 held -> grant=3'b010. Master 1 writes adr 0x0012, dat 0xA5; slave acks -> m_ack=3'b010. Master 1 drops cyc -> IDLE 1 cycle -> grant=3'b100.
- Round robin: NUM_MASTERS=4, RR_MODE=1, all m_cyc=1, each master does one ack'd beat then drops cyc for one cycle -> grant order 0001, 0010, 0100, 1000, 0001.
- Block hold: master 2 keeps cyc high for 4 stb/ack beats, adr 0x0000..0x0003, while master 0 requests -> grant stays 100 for all 4 acks; master 0 is granted only after the turnaround.
- Read path: slave returns s_dat_r=0x3C with ack to granted master 1 -> m_dat_r=0x3C, m_ack[1]=1, m_ack[0]=m_ack[2]=0.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks -> m_err[g]=1 for exactly 1 cycle, 8 cycles after stb. grant then returns to 0 and the next requester is served.
